// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED mode controller: press-classifier states,
// display modes and per-mode pattern seeds.
package led_ctrl_pkg;

    typedef enum logic [2:0] {
        PS_DISARMED,
        PS_IDLE,
        PS_PRESS1,
        PS_HELD,
        PS_GAP,
        PS_PRESS2
    } press_state_t;

    typedef enum logic [1:0] {
        M_BIN,
        M_CHASE,
        M_BLINK,
        M_OFF
    } mode_t;

    localparam logic [3:0] SEED_BIN   = 4'h0;
    localparam logic [3:0] SEED_CHASE = 4'h1;
    localparam logic [3:0] SEED_BLINK = 4'h0;
    localparam logic [3:0] SEED_OFF   = 4'h0;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            M_BIN:   return M_CHASE;
            M_CHASE: return M_BLINK;
            M_BLINK: return M_OFF;
            default: return M_BIN;
        endcase
    endfunction

    function automatic logic [3:0] mode_seed(input mode_t m);
        case (m)
            M_BIN:   return SEED_BIN;
            M_CHASE: return SEED_CHASE;
            M_BLINK: return SEED_BLINK;
            default: return SEED_OFF;
        endcase
    endfunction

endpackage

// File: rtl/btn_event_fsm.sv
// Classifies presses of a clean active-low button into short, long and double events.
// Event outputs are single-cycle pulses decoded from the current state and button level.
module btn_event_fsm
    import led_ctrl_pkg::*;
#(
    parameter int LONG_CYC   = 50_000_000,
    parameter int DCLICK_CYC = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic evt_short,
    output logic evt_long,
    output logic evt_double
);

    localparam int MAX_CYC = (LONG_CYC > DCLICK_CYC) ? LONG_CYC : DCLICK_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(MAX_CYC);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYC - 1);

    press_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;

    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PS_DISARMED;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        evt_short  = 1'b0;
        evt_long   = 1'b0;
        evt_double = 1'b0;
        case (state)
            // A button already held when reset lifts must be released before arming.
            PS_DISARMED: begin
                if (btn_n) state_nxt = PS_IDLE;
            end
            PS_IDLE: begin
                if (!btn_n) begin
                    state_nxt = PS_PRESS1;
                    cnt_nxt   = '0;
                end
            end
            PS_PRESS1: begin
                if (btn_n) begin
                    state_nxt = PS_GAP;
                    cnt_nxt   = '0;
                end else if (cnt == LONG_LAST) begin
                    evt_long  = 1'b1;
                    state_nxt = PS_HELD;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            PS_HELD: begin
                if (btn_n) state_nxt = PS_IDLE;
            end
            PS_GAP: begin
                if (!btn_n) begin
                    state_nxt = PS_PRESS2;
                end else if (cnt == DCLICK_LAST) begin
                    evt_short = 1'b1;
                    state_nxt = PS_IDLE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            PS_PRESS2: begin
                if (btn_n) begin
                    evt_double = 1'b1;
                    state_nxt  = PS_IDLE;
                end
            end
            default: state_nxt = PS_DISARMED;
        endcase
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// LED mode controller: button events select mode, run/pause and direction of a
// 4-bit pattern engine stepped by a periodic tick; LEDs are driven active-low.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int LONG_CYC   = 50_000_000,
    parameter int DCLICK_CYC = 12_500_000,
    parameter int TICK_CYC   = 12_500_000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       btn_n_i,
    output logic [3:0] led_n_o,
    output logic [1:0] mode_o,
    output logic       run_o,
    output logic       dir_o,
    output logic       evt_short_o,
    output logic       evt_long_o,
    output logic       evt_double_o
);

    localparam int TICK_W = $clog2(TICK_CYC) + 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);

    logic              evt_short, evt_long, evt_double;
    mode_t             mode;
    logic              run, dir, tick;
    logic [3:0]        pat;
    logic [TICK_W-1:0] tick_cnt;

    function automatic logic [3:0] pat_step(input mode_t m, input logic d, input logic [3:0] p);
        case (m)
            M_BIN:   return d ? p - 4'd1 : p + 4'd1;
            M_CHASE: return d ? {p[0], p[3:1]} : {p[2:0], p[3]};
            M_BLINK: return ~p;
            default: return 4'h0;
        endcase
    endfunction

    btn_event_fsm #(
        .LONG_CYC   (LONG_CYC),
        .DCLICK_CYC (DCLICK_CYC)
    ) u_btn_event_fsm (
        .clk        (clk_i),
        .rst_n      (rst_n_i),
        .btn_n      (btn_n_i),
        .evt_short  (evt_short),
        .evt_long   (evt_long),
        .evt_double (evt_double)
    );

    assign tick = run && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode <= M_BIN;
            run  <= 1'b1;
            dir  <= 1'b0;
        end else begin
            if (evt_short)  mode <= next_mode(mode);
            if (evt_long)   run  <= ~run;
            if (evt_double) dir  <= ~dir;
        end
    end

    // A mode change restarts the step period so the new seed is shown for a full tick.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tick_cnt <= '0;
        end else if (evt_short) begin
            tick_cnt <= '0;
        end else if (run) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    // Any event in the same cycle as a tick takes precedence and the step is dropped.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pat <= 4'h0;
        end else if (evt_short) begin
            pat <= mode_seed(next_mode(mode));
        end else if (tick && !evt_long && !evt_double) begin
            pat <= pat_step(mode, dir, pat);
        end
    end

    assign led_n_o      = ~pat;
    assign mode_o       = mode;
    assign run_o        = run;
    assign dir_o        = dir;
    assign evt_short_o  = evt_short;
    assign evt_long_o   = evt_long;
    assign evt_double_o = evt_double;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl: stimulus queues expected events and LED values,
// a negedge monitor pops and compares them whenever the DUT presents them.
module tb_led_mode_ctrl;

    localparam int LONG_CYC   = 20;
    localparam int DCLICK_CYC = 10;
    localparam int TICK_CYC   = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_n = 1'b1;
    logic [3:0] led_n;
    logic [1:0] mode;
    logic       run, dir, evt_short, evt_long, evt_double;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // kind: 0 short, 1 long, 2 double; mode/run/dir are the values expected after the event
    typedef struct {int kind; int at; int mode; int run; int dir;} ev_t;
    typedef struct {int val; int gap;} led_t;

    ev_t  ev_q[$];
    led_t led_q[$];
    bit   led_chk  = 1'b0;
    int   led_from = 0;

    ev_t  mon_e;
    ev_t  st_exp;
    bit   st_pend  = 1'b0;
    led_t mon_l;
    int   mon_kind;
    int   prev_led = 15;
    int   last_chg = 0;

    led_mode_ctrl #(
        .LONG_CYC   (LONG_CYC),
        .DCLICK_CYC (DCLICK_CYC),
        .TICK_CYC   (TICK_CYC)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .btn_n_i      (btn_n),
        .led_n_o      (led_n),
        .mode_o       (mode),
        .run_o        (run),
        .dir_o        (dir),
        .evt_short_o  (evt_short),
        .evt_long_o   (evt_long),
        .evt_double_o (evt_double)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic led_cmp();
        mon_l = led_q.pop_front();
        chk("led_n value", int'(led_n), mon_l.val);
        if (mon_l.gap != 0) chk("led step period", cyc - last_chg, mon_l.gap);
        last_chg = cyc;
    endtask

    always @(negedge clk) begin
        if (st_pend) begin
            chk("mode after event", int'(mode), st_exp.mode);
            chk("run after event", int'(run), st_exp.run);
            chk("dir after event", int'(dir), st_exp.dir);
            st_pend = 1'b0;
        end
        if (evt_short || evt_long || evt_double) begin
            mon_kind = evt_short ? 0 : (evt_long ? 1 : 2);
            chk("single event pulse", int'(evt_short) + int'(evt_long) + int'(evt_double), 1);
            checks++;
            if (ev_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected event: kind %0d at cycle %0d, none expected", mon_kind, cyc);
            end else begin
                mon_e = ev_q.pop_front();
                chk("event kind", mon_kind, mon_e.kind);
                chk("event cycle", cyc, mon_e.at);
                st_exp  = mon_e;
                st_pend = 1'b1;
            end
        end
        if (led_chk && cyc >= led_from) begin
            if (cyc == led_from) begin
                if (led_q.size() > 0) led_cmp();
            end else if (int'(led_n) != prev_led) begin
                checks++;
                if (led_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected led change at cycle %0d: got %0h, expected %0h", cyc, led_n, prev_led);
                end else begin
                    checks--;
                    led_cmp();
                end
            end
        end
        prev_led = int'(led_n);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((ev_q.size() != 0 || led_q.size() != 0 || st_pend) && n < budget) begin
            step(1);
            n++;
        end
        chk("queues drained in budget", ev_q.size() + led_q.size(), 0);
    endtask

    task automatic short_press(input int m, input int rn, input int dr, output int r);
        step(1);
        btn_n = 1'b0;
        step(5);
        btn_n = 1'b1;
        r = cyc;
        ev_q.push_back(ev_t'{0, r + DCLICK_CYC, m, rn, dr});
    endtask

    task automatic reset_checks();
        chk("reset led_n", int'(led_n), 15);
        chk("reset mode", int'(mode), 0);
        chk("reset run", int'(run), 1);
        chk("reset dir", int'(dir), 0);
        chk("reset events", int'(evt_short) + int'(evt_long) + int'(evt_double), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k0, r, c, s9;

        // reset state, then free-running BIN count with wrap
        step(3);
        reset_checks();
        k0 = cyc + 1;
        led_from = k0 + 1;
        led_q.push_back(led_t'{15, 0});
        led_q.push_back(led_t'{14, 3});
        for (int p = 2; p < 16; p++) led_q.push_back(led_t'{15 - p, 4});
        led_q.push_back(led_t'{15, 4});
        led_chk = 1'b1;
        step(1);
        rst_n = 1'b1;
        wait_drain(100);
        led_chk = 1'b0;

        // short press -> CHASE, rotate left
        short_press(1, 1, 0, r);
        led_from = r + 11;
        led_q.push_back(led_t'{14, 0});
        led_q.push_back(led_t'{13, 4});
        led_q.push_back(led_t'{11, 4});
        led_q.push_back(led_t'{7, 4});
        led_q.push_back(led_t'{14, 4});
        led_chk = 1'b1;
        wait_drain(60);
        led_chk = 1'b0;

        // long press pauses; pattern must freeze; release gives no event
        step(1);
        btn_n = 1'b0;
        c = cyc;
        ev_q.push_back(ev_t'{1, c + LONG_CYC, 1, 0, 0});
        led_from = c + LONG_CYC + 1;
        led_chk = 1'b1;
        step(25);
        btn_n = 1'b1;
        step(20);
        wait_drain(10);

        // paused short presses walk CHASE -> BLINK -> OFF -> BIN, showing each seed
        short_press(2, 0, 0, r);
        led_from = r + 11;
        led_q.push_back(led_t'{15, 0});
        wait_drain(30);
        short_press(3, 0, 0, r);
        led_from = r + 11;
        led_q.push_back(led_t'{15, 0});
        wait_drain(30);
        short_press(0, 0, 0, r);
        led_from = r + 11;
        led_q.push_back(led_t'{15, 0});
        wait_drain(30);

        // double press: low 5, high 3, low 4, release -> dir flips, no short
        step(1);
        btn_n = 1'b0;
        step(5);
        btn_n = 1'b1;
        step(3);
        btn_n = 1'b0;
        step(4);
        btn_n = 1'b1;
        ev_q.push_back(ev_t'{2, cyc, 0, 0, 1});
        step(20);
        wait_drain(10);

        // long press resumes; BIN now counts down 0 -> F -> E -> D
        step(1);
        btn_n = 1'b0;
        c = cyc;
        ev_q.push_back(ev_t'{1, c + LONG_CYC, 0, 1, 1});
        led_from = c + LONG_CYC + 1;
        led_q.push_back(led_t'{15, 0});
        led_q.push_back(led_t'{0, 4});
        led_q.push_back(led_t'{1, 4});
        led_q.push_back(led_t'{2, 4});
        step(25);
        btn_n = 1'b1;
        wait_drain(40);
        led_chk = 1'b0;

        // button held through reset: no events; later short press still works
        step(1);
        btn_n = 1'b0;
        rst_n = 1'b0;
        step(3);
        reset_checks();
        rst_n = 1'b1;
        step(30);
        btn_n = 1'b1;
        step(20);
        short_press(1, 1, 0, r);
        s9 = r + DCLICK_CYC;
        led_from = r + 11;
        led_q.push_back(led_t'{14, 0});
        led_q.push_back(led_t'{13, 4});
        led_chk = 1'b1;
        wait_drain(40);
        led_chk = 1'b0;

        // short event lands on a tick cycle (s9+28): seed shown, step dropped
        while (cyc < s9 + 13) step(1);
        btn_n = 1'b0;
        step(5);
        btn_n = 1'b1;
        r = cyc;
        ev_q.push_back(ev_t'{0, r + DCLICK_CYC, 2, 1, 0});
        led_from = r + 11;
        led_q.push_back(led_t'{15, 0});
        led_q.push_back(led_t'{0, 4});
        led_q.push_back(led_t'{15, 4});
        led_chk = 1'b1;
        wait_drain(40);
        led_chk = 1'b0;

        step(5);
        chk("event queue empty", ev_q.size(), 0);
        chk("led queue empty", led_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
